// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer and flag logic for an asynchronous FIFO.
//   Tracks the binary write pointer, publishes its Gray code to the read domain,
//   and derives full / almost-full / fill level against the synchronized read pointer.
//   Optional sticky overflow flag is enabled by defining WPTR_FULL_OVF_EN.
// Ports:
//   w_clk          write-domain clock
//   rst_n          asynchronous active-low reset
//   w_en           write request (accepted only when not full)
//   wsync_ptr2     Gray read pointer, already synchronized into w_clk
//   w_ovf_clr      clears the sticky overflow flag
//   waddr          storage RAM write address
//   wptr           registered Gray write pointer
//   w_full         FIFO full
//   w_almost_full  fill level >= AF_LEVEL
//   w_level        registered fill count, 0..DEPTH
//   w_ovf          sticky overflow flag (tied to 0 when WPTR_FULL_OVF_EN is undefined)
module wptr_full #(
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          w_clk,
   input  logic          rst_n,
   input  logic          w_en,
   input  logic [AW:0]   wsync_ptr2,
   input  logic          w_ovf_clr,
   output logic [AW-1:0] waddr,
   output logic [AW:0]   wptr,
   output logic          w_full,
   output logic          w_almost_full,
   output logic [AW:0]   w_level,
   output logic          w_ovf
);
   localparam logic [AW:0] AF = AF_LEVEL[AW:0];
   logic [AW:0] wbin, wbin_nx, wgray_nx, rbin, level_nx;
   logic        acc;
   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i <= AW; i++) begin : g_rbin
      assign rbin[i] = ^(wsync_ptr2 >> i);
   end
   assign acc      = w_en & ~w_full;
   assign wbin_nx  = acc ? wbin + (AW+1)'(1) : wbin;
   assign wgray_nx = wbin_nx ^ (wbin_nx >> 1);
   assign level_nx = wbin_nx - rbin;
   assign waddr    = wbin[AW-1:0];
   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin          <= '0;
         wptr          <= '0;
         w_full        <= 1'b0;
         w_almost_full <= 1'b0;
         w_level       <= '0;
      end else begin
         wbin          <= wbin_nx;
         wptr          <= wgray_nx;
         // Full when the write pointer is one lap ahead: top two Gray bits inverted.
         w_full        <= wgray_nx == {~wsync_ptr2[AW:AW-1], wsync_ptr2[AW-2:0]};
         w_almost_full <= level_nx >= AF;
         w_level       <= level_nx;
      end
   end
`ifdef WPTR_FULL_OVF_EN
   // A rejected write sets the flag; set takes priority over a simultaneous clear.
   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) w_ovf <= 1'b0;
      else if (w_en & w_full) w_ovf <= 1'b1;
      else if (w_ovf_clr) w_ovf <= 1'b0;
   end
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = w_ovf_clr;
   assign w_ovf          = 1'b0;
`endif
endmodule
